// File: rtl/watermark_pixel_writer.sv
// Output stage of the watermarking core: reorders block-order pixels into raster
// addresses and writes them one per word through a small backpressure FIFO.
module watermark_pixel_writer #(
    parameter int          Amba_Word       = 16,
    parameter int          Amba_Addr_Depth = 20,
    parameter int          Data_Depth      = 8,
    parameter int          Fifo_Depth      = 16,
    parameter int unsigned Out_Base        = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_load,
    input  logic [9:0]                 cfg_Np,
    input  logic [7:0]                 cfg_M,
    input  logic [Data_Depth-1:0]      Pixel_Data,
    input  logic                       new_pixel,
    input  logic                       wr_ready,
    output logic                       wr_en,
    output logic [Amba_Addr_Depth:0]   wr_addr,
    output logic [Amba_Word-1:0]       wr_data,
    output logic                       overflow,
    output logic                       Out_Done,
    output logic [1:0]                 o_dbg_state
);
    localparam int AW = Amba_Addr_Depth + 1;
    localparam int FW = $clog2(Fifo_Depth);
    localparam int EW = AW + Data_Depth;
    localparam logic [AW-1:0] BASE      = AW'(Out_Base);
    localparam logic [FW:0]   CNT_FULL  = (FW+1)'(Fifo_Depth);
    localparam logic [FW:0]   CNT_ONE   = (FW+1)'(1);

    // Write side handshake: a word transfers on any clock edge where wr_en and
    // wr_ready are both high; wr_addr/wr_data stay stable until that edge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t r_state, w_next;

    logic [9:0]    r_np;
    logic [7:0]    r_m;
    logic [AW-1:0] r_mnp;
    logic [19:0]   r_total;
    logic [19:0]   r_pix_cnt;
    logic [7:0]    r_col, r_row;
    logic [10:0]   r_bcol;
    logic [AW-1:0] r_pix_addr, r_line_base, r_blk_base, r_brow_base;
    logic          r_ovf;

    logic [EW-1:0] r_mem [Fifo_Depth];
    logic [FW-1:0] r_wptr, r_rptr;
    logic [FW:0]   r_count;

    logic          w_accept, w_pop, w_push, w_drop, w_full, w_last_pix;
    logic          w_col_end, w_row_end, w_bcol_end;
    logic [10:0]   w_bcol_sum;
    logic [AW-1:0] w_line_next, w_blk_next, w_brow_next;
    logic [AW-1:0] w_head_addr;
    logic [Data_Depth-1:0] w_head_data;

    assign w_accept   = (r_state == RUN) && new_pixel && !cfg_load;
    assign wr_en      = (r_count != '0);
    assign w_pop      = wr_en && wr_ready && !cfg_load;
    assign w_full     = (r_count == CNT_FULL);
    assign w_push     = w_accept && (!w_full || w_pop);
    assign w_drop     = w_accept && w_full && !w_pop;
    assign w_last_pix = w_accept && ((r_pix_cnt + 20'd1) == r_total);

    // col/row never exceed M-1, so comparing against M-1 avoids 8-bit wrap at M=255.
    assign w_col_end   = (r_col == r_m - 8'd1);
    assign w_row_end   = (r_row == r_m - 8'd1);
    // r_bcol tracks the block column in pixel units, so Np/M is never needed.
    assign w_bcol_sum  = r_bcol + {3'b000, r_m};
    assign w_bcol_end  = (w_bcol_sum >= {1'b0, r_np});
    assign w_line_next = r_line_base + AW'(r_np);
    assign w_blk_next  = r_blk_base + AW'(r_m);
    assign w_brow_next = r_brow_base + r_mnp;

    always_comb begin
        w_next = r_state;
        if (cfg_load) begin
            w_next = (cfg_M != 8'd0) ? RUN : IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next = IDLE;
                RUN:     if (w_last_pix) w_next = DRAIN;
                DRAIN:   if ((r_count == '0) || (w_pop && r_count == CNT_ONE)) w_next = DONE;
                DONE:    w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_np        <= '0;
            r_m         <= '0;
            r_mnp       <= '0;
            r_total     <= '0;
            r_pix_cnt   <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_bcol      <= '0;
            r_pix_addr  <= '0;
            r_line_base <= '0;
            r_blk_base  <= '0;
            r_brow_base <= '0;
            r_ovf       <= 1'b0;
        end else if (cfg_load) begin
            r_np        <= cfg_Np;
            r_m         <= cfg_M;
            r_mnp       <= AW'(cfg_M) * AW'(cfg_Np);
            r_total     <= 20'(cfg_Np) * 20'(cfg_Np);
            r_pix_cnt   <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_bcol      <= '0;
            r_pix_addr  <= '0;
            r_line_base <= '0;
            r_blk_base  <= '0;
            r_brow_base <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_drop) r_ovf <= 1'b1;
            // Counters advance even for dropped pixels so later addresses stay right.
            if (w_accept) begin
                r_pix_cnt <= r_pix_cnt + 20'd1;
                if (!w_col_end) begin
                    r_col      <= r_col + 8'd1;
                    r_pix_addr <= r_pix_addr + AW'(1);
                end else begin
                    r_col <= '0;
                    if (!w_row_end) begin
                        r_row       <= r_row + 8'd1;
                        r_line_base <= w_line_next;
                        r_pix_addr  <= w_line_next;
                    end else begin
                        r_row <= '0;
                        if (!w_bcol_end) begin
                            r_bcol      <= w_bcol_sum;
                            r_blk_base  <= w_blk_next;
                            r_line_base <= w_blk_next;
                            r_pix_addr  <= w_blk_next;
                        end else begin
                            r_bcol      <= '0;
                            r_brow_base <= w_brow_next;
                            r_blk_base  <= w_brow_next;
                            r_line_base <= w_brow_next;
                            r_pix_addr  <= w_brow_next;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (cfg_load) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + FW'(1);
            if (w_pop)  r_rptr <= r_rptr + FW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
        end
    end

    // When full, a push lands in the slot being popped on the same edge.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {BASE + r_pix_addr, Pixel_Data};
    end

    assign {w_head_addr, w_head_data} = r_mem[r_rptr];
    assign wr_addr     = wr_en ? w_head_addr : '0;
    assign wr_data     = wr_en ? Amba_Word'(w_head_data) : '0;
    assign overflow    = r_ovf;
    assign Out_Done    = (r_state == DONE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_watermark_pixel_writer.sv
// Bench for watermark_pixel_writer: fixed raster/uneven tables, hand-written
// corner sequences, and randomized traffic against a raster-arithmetic model.
module tb_watermark_pixel_writer;
    localparam int AW = 21;
    localparam int WW = 16;
    localparam int FD = 16;
    localparam logic [AW-1:0] OUT_BASE = 21'h100;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_load;
    logic [9:0]    cfg_Np;
    logic [7:0]    cfg_M;
    logic [7:0]    Pixel_Data;
    logic          new_pixel;
    logic          wr_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_data;
    logic          overflow;
    logic          Out_Done;
    logic [1:0]    o_dbg_state;

    watermark_pixel_writer #(
        .Amba_Word(16), .Amba_Addr_Depth(20), .Data_Depth(8),
        .Fifo_Depth(FD), .Out_Base(32'h100)
    ) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_Np(cfg_Np), .cfg_M(cfg_M),
        .Pixel_Data(Pixel_Data), .new_pixel(new_pixel), .wr_ready(wr_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .overflow(overflow),
        .Out_Done(Out_Done), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            np;
        int            m;
        int            idx;
        logic [AW-1:0] exp_addr;
        logic [WW-1:0] exp_data;
    } vec_t;

    vec_t vecs[26];
    int   ras[16];
    int   une[10];

    logic [AW+WW-1:0] exp_q[$];
    logic [AW+WW-1:0] got_q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_hs  = 0;

    int m_np, m_m, m_cnt, m_total;
    bit m_run, m_drain, m_done, m_ovf;
    int mon_sz;
    bit mon_pop;

    task automatic check(input string name, input logic [AW+WW-1:0] act, input logic [AW+WW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Raster address of the k-th pixel in block-arrival order.
    function automatic logic [AW-1:0] addr_of(input int k, input int np, input int m);
        int bpr, blk, w, r, c;
        bpr = np / m;
        blk = k / (m * m);
        w   = k % (m * m);
        r   = w / m;
        c   = w % m;
        return OUT_BASE + AW'(((blk / bpr) * m + r) * np + (blk % bpr) * m + c);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_cnt = 0; m_run = 0; m_drain = 0; m_done = 0; m_ovf = 0;
    endtask

    // Outputs are compared with the model state, then the model steps through
    // what the coming rising edge will do with the inputs now applied.
    always @(negedge clk) begin
        if (!rst) begin
            model_clear();
        end else begin
            mon_sz = exp_q.size();
            check("wr_en", {36'd0, wr_en}, {36'd0, mon_sz != 0});
            if (mon_sz != 0) check("wr_word", {wr_addr, wr_data}, exp_q[0]);
            check("overflow", {36'd0, overflow}, {36'd0, m_ovf});
            check("Out_Done", {36'd0, Out_Done}, {36'd0, m_done});
            if (wr_en && wr_ready && !cfg_load) begin
                got_q.push_back({wr_addr, wr_data});
                n_hs++;
            end
            mon_pop = (mon_sz != 0) && wr_ready && !cfg_load;
            if (mon_pop) void'(exp_q.pop_front());
            if (cfg_load) begin
                model_clear();
                m_np = int'(cfg_Np);
                m_m = int'(cfg_M);
                m_total = m_np * m_np;
                m_run = (cfg_M != 8'd0);
            end else begin
                if (m_drain && mon_pop && exp_q.size() == 0) begin
                    m_drain = 0;
                    m_done = 1;
                end
                if (m_run && new_pixel) begin
                    if (mon_sz < FD || mon_pop)
                        exp_q.push_back({addr_of(m_cnt, m_np, m_m), 8'h00, Pixel_Data});
                    else
                        m_ovf = 1;
                    m_cnt++;
                    if (m_cnt == m_total) begin
                        m_run = 0;
                        m_drain = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_cfg(input int np, input int m);
        cfg_Np = 10'(np);
        cfg_M = 8'(m);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        Pixel_Data = d;
        new_pixel = 1'b1;
        tick();
        new_pixel = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !Out_Done; i++) tick();
        check(name, {36'd0, Out_Done}, 37'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    int cfg_np_l[6] = '{4, 6, 8, 8, 5, 12};
    int cfg_m_l[6]  = '{2, 3, 4, 1, 5, 3};

    initial begin
        rst = 1'b0; cfg_load = 1'b0; cfg_Np = '0; cfg_M = '0;
        Pixel_Data = '0; new_pixel = 1'b0; wr_ready = 1'b0;

        ras = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        une = '{0, 1, 2, 6, 7, 8, 12, 13, 14, 3};
        for (int i = 0; i < 16; i++) vecs[i] = '{4, 2, i, OUT_BASE + AW'(ras[i]), 16'(i)};
        for (int i = 0; i < 10; i++) vecs[16 + i] = '{6, 3, i, OUT_BASE + AW'(une[i]), 16'(8'h40 + i)};

        // Reset values
        idle(3);
        check("rst_wr_en", {36'd0, wr_en}, 37'd0);
        check("rst_wr_addr", 37'(wr_addr), 37'd0);
        check("rst_wr_data", 37'(wr_data), 37'd0);
        check("rst_overflow", {36'd0, overflow}, 37'd0);
        check("rst_Out_Done", {36'd0, Out_Done}, 37'd0);
        check("rst_state", 37'(o_dbg_state), 37'd0);
        rst = 1'b1;
        tick();

        send(8'hAA);
        send(8'hBB);
        idle(3);
        check("idle_ignores_pixels", {36'd0, wr_en}, 37'd0);

        // Table-driven raster (4/2, back-to-back) and uneven (6/3, gaps) cases
        wr_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            int np, m;
            np = (t == 0) ? 4 : 6;
            m  = (t == 0) ? 2 : 3;
            do_cfg(np, m);
            got_q.delete();
            for (int i = 0; i < np * np; i++) begin
                send((t == 0) ? 8'(i) : 8'(8'h40 + i));
                if (t == 1) idle($urandom_range(0, 2));
            end
            wait_done("table_done", 200);
            check("table_writes", 37'(got_q.size()), 37'(np * np));
            for (int i = 0; i < 26; i++) begin
                if (vecs[i].np == np) begin
                    if (vecs[i].idx < got_q.size())
                        check("table_word", got_q[vecs[i].idx], {vecs[i].exp_addr, vecs[i].exp_data});
                    else
                        check("table_missing", 37'(got_q.size()), 37'(vecs[i].idx + 1));
                end
            end
            check("done_state", 37'(o_dbg_state), 37'd3);
        end

        // Fill the FIFO under backpressure, then push+pop together, then drop
        wr_ready = 1'b0;
        do_cfg(8, 2);
        for (int i = 0; i < FD; i++) send(8'($urandom));
        check("full_ovf", {36'd0, overflow}, 37'd0);
        check("full_wr_en", {36'd0, wr_en}, 37'd1);
        check("full_addr", 37'(wr_addr), 37'(OUT_BASE));
        wr_ready = 1'b1;
        send(8'h5A);
        wr_ready = 1'b0;
        check("pushpop_ovf", {36'd0, overflow}, 37'd0);
        send(8'hC3);
        check("drop_ovf", {36'd0, overflow}, 37'd1);
        n_hs = 0;
        wr_ready = 1'b1;
        idle(30);
        check("drain_writes", 37'(n_hs), 37'(FD));

        // Abort with cfg_load coincident with a handshake and a pixel
        wr_ready = 1'b0;
        do_cfg(4, 2);
        for (int i = 0; i < 5; i++) send(8'(i + 1));
        wr_ready = 1'b1;
        new_pixel = 1'b1;
        Pixel_Data = 8'hEE;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        new_pixel = 1'b0;
        check("abort_wr_en", {36'd0, wr_en}, 37'd0);
        send(8'h77);
        check("abort_next_word", {wr_addr, wr_data}, {OUT_BASE, 16'h0077});
        for (int i = 1; i < 16; i++) send(8'(i));
        wait_done("abort_done", 100);

        do_cfg(4, 0);
        for (int i = 0; i < 3; i++) send(8'(i));
        idle(3);
        check("m0_wr_en", {36'd0, wr_en}, 37'd0);
        check("m0_state", 37'(o_dbg_state), 37'd0);

        // Randomized traffic across several geometries
        for (int c = 0; c < 6; c++) begin
            int sent, rdy_lo;
            do_cfg(cfg_np_l[c], cfg_m_l[c]);
            sent = 0;
            rdy_lo = (c % 2 == 0) ? 1 : 2;
            while (sent < cfg_np_l[c] * cfg_np_l[c]) begin
                new_pixel = ($urandom_range(0, 3) != 0);
                Pixel_Data = 8'($urandom);
                wr_ready = ($urandom_range(0, 3) >= rdy_lo);
                if (new_pixel) sent++;
                tick();
            end
            new_pixel = 1'b0;
            wr_ready = 1'b1;
            wait_done("rand_done", 300);
            send(8'h99);
            idle(2);
        end

        // Asynchronous reset mid-RUN
        wr_ready = 1'b0;
        do_cfg(4, 2);
        for (int i = 0; i < 3; i++) send(8'(8'h30 + i));
        #2;
        rst = 1'b0;
        #1;
        check("arst_wr_en", {36'd0, wr_en}, 37'd0);
        check("arst_wr_addr", 37'(wr_addr), 37'd0);
        check("arst_wr_data", 37'(wr_data), 37'd0);
        check("arst_overflow", {36'd0, overflow}, 37'd0);
        check("arst_Out_Done", {36'd0, Out_Done}, 37'd0);
        idle(2);
        rst = 1'b1;
        send(8'h11);
        send(8'h22);
        idle(2);
        check("post_rst_wr_en", {36'd0, wr_en}, 37'd0);
        check("post_rst_state", 37'(o_dbg_state), 37'd0);
        wr_ready = 1'b1;
        do_cfg(4, 2);
        for (int i = 0; i < 16; i++) send(8'($urandom));
        wait_done("post_rst_done", 100);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/watermark_pixel_writer.md
# watermark_pixel_writer

Downstream stage of the visible-watermarking core: it captures each modified pixel (`Pixel_Data` qualified by `new_pixel`), converts block-order arrival into raster addresses, and writes the pixels one per word into the output image bank. A small FIFO absorbs write-side backpressure, because the producing core cannot be stalled. The block signals completion once all `Np*Np` pixels have been written.

## Interface
- `Amba_Word`, 16, write data width.
- `Amba_Addr_Depth`, 20, output address is `Amba_Addr_Depth+1` bits wide.
- `Data_Depth`, 8, pixel width.
- `Fifo_Depth`, 16, pixel FIFO entries; must be a power of 2.
- `Out_Base`, 0, address of output pixel (0,0).

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `cfg_load`  in  1  one-cycle strobe that latches `cfg_Np`/`cfg_M` and restarts the block.
- `cfg_Np`  in  10  image side in pixels.
- `cfg_M`  in  8  block side in pixels.
- `Pixel_Data`  in  Data_Depth  modified pixel from the core.
- `new_pixel`  in  1  `Pixel_Data` valid this cycle.
- `wr_ready`  in  1  output bank accepts a write this cycle.
- `wr_en`  out  1  write request; `wr_addr`/`wr_data` are valid while it is high.
- `wr_addr`  out  Amba_Addr_Depth+1  raster address of the pixel.
- `wr_data`  out  Amba_Word  pixel, zero-extended.
- `overflow`  out  1  sticky; a pixel was dropped.
- `Out_Done`  out  1  all pixels written.

## Operation
- **States.** IDLE → RUN → DRAIN → DONE.
- **IDLE.**
  - `cfg_load` with `cfg_M != 0` → RUN.
  - `cfg_load` with `cfg_M == 0` stays in IDLE.
  - `new_pixel` is ignored.
- **Arrival order.** Pixels arrive block by block, blocks in raster order across the image. Within a block, pixels are in raster order, `M` columns × `M` rows. There are `Np/M` blocks per block-row. `Np` is guaranteed to be a multiple of `M` (not checked).
- **Address generation (RUN, on each accepted `new_pixel`).** No multipliers; all updates are incremental using counters `col`, `row`, `bcol`, plus registers `pix_addr`, `line_base`, `blk_base`, `brow_base`.
  - `col+1 < M`: `pix_addr += 1`.
  - Else, if `row+1 < M`: `line_base += Np`, `pix_addr = line_base+Np`.
  - Else, if `bcol+1 < Np/M`: `blk_base += M`, and `pix_addr`/`line_base` take the new `blk_base`.
  - Else: `brow_base += M*Np`, and all bases take the new `brow_base`. `M*Np` is precomputed once at `cfg_load`.
  - Each accepted pixel pushes {`Out_Base+pix_addr`, pixel} into the FIFO. A 20-bit counter `pix_cnt` increments.
- **RUN → DRAIN** when `pix_cnt` reaches `Np*Np`. Further `new_pixel` strobes are ignored and do not set `overflow`.
- **DRAIN → DONE** on the write handshake of the last FIFO entry.
- **DONE.** `Out_Done` stays high until `cfg_load` or reset.
- **FIFO.**
  - Push while full is allowed only if a pop occurs the same cycle.
  - Otherwise the pixel is dropped, `overflow` sets, and the address counters still advance, so later pixels keep correct addresses.
- **`cfg_load` in any state.**
  - Flushes the FIFO.
  - Clears `overflow`, `Out_Done`, `pix_cnt` and all counters.
  - Latches the new configuration.
- **Arithmetic.** `wr_addr` is truncated to `Amba_Addr_Depth+1` bits. `Out_Base+Np*Np` must fit; it is not checked.

## Timing
- **Reset values.** `wr_en`=0, `wr_addr`=0, `wr_data`=0, `overflow`=0, `Out_Done`=0; state IDLE; FIFO empty.
- **Capture.** A pixel is captured on the edge where `new_pixel`=1. `wr_en` can rise the following cycle, a 1-cycle minimum latency.
- **Handshake.**
  - A transfer completes on the edge where `wr_en && wr_ready`.
  - The next entry is presented the following cycle, so the write side sustains 1 word/cycle.
  - `wr_addr`/`wr_data` hold steady while `wr_en && !wr_ready`.
- **Simultaneous push and pop** on the same edge: FIFO occupancy is unchanged.
- **`Out_Done`** rises the cycle after the last handshake.
- **`cfg_load` coincident with a handshake:** the handshake is discarded and `wr_en`=0 next cycle.
- **`cfg_load` coincident with `new_pixel`:** the pixel is ignored.
- **Reset mid-operation** returns every output to its reset value immediately (asynchronous).

## Test plan
- **Raster reorder.** `Np`=4, `M`=2, `Out_Base`=0, `wr_ready`=1; pixels 0..15 on consecutive cycles. Expect `wr_addr` sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15 with matching `wr_data`, and `Out_Done` one cycle after the 16th write.
- **Uneven blocks.** `Np`=6, `M`=3, `Out_Base`=0x100. Expect the first 9 addresses 0x100,101,102,106,107,108,10C,10D,10E and the 10th address 0x103.
- **Backpressure.** `wr_ready`=0 while 16 pixels arrive (`Fifo_Depth`=16) → `overflow`=0 and `wr_en` held with address 0. A 17th pixel → `overflow`=1, and after release only 16 writes occur, at the correct addresses.
- **Full FIFO with simultaneous pop.** Fill the FIFO, then assert `wr_ready`=1 and `new_pixel` on the same cycle → no drop, `overflow` stays 0.
- **Abort.** `cfg_load` after 5 of 16 pixels → FIFO empty, `wr_en`=0 next cycle; the next pixel is written to address `Out_Base`. `cfg_M`=0 → the block stays IDLE and no writes occur.
- **Reset.** Drive `rst` low mid-RUN → all outputs go to 0 asynchronously; after release the block stays in IDLE until `cfg_load`.
